// File: rtl/islip_grant_arbiter.sv
// Output-port grant stage of op-iSLIP: strict level priority, round-robin per level, one grant held until handshake/timeout.
// Latency: request sampled at edge k -> grant visible after k; o_timeout is a registered one-cycle pulse.
// Backpressure: while a grant is held, new requests are ignored; optional stats via ISLIP_GRANT_STATS_EN.
module islip_grant_arbiter #(
    parameter int N       = 25,
    parameter int P       = 8,
    parameter int TIMEOUT = 15,
    localparam int LW = (P > 1) ? $clog2(P) : 1,
    localparam int PW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [P*N-1:0]  i_request,
    input  logic            i_req_valid,
    input  logic            i_accept,
    input  logic            i_reject,
    output logic [N-1:0]    o_grant,
    output logic [LW-1:0]   o_grant_level,
    output logic            o_grant_valid,
`ifdef ISLIP_GRANT_STATS_EN
    output logic [15:0]     o_accept_cnt,
    output logic [15:0]     o_timeout_cnt,
`endif
    output logic            o_timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr [P];
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] next_ptr;
    logic          to_hit;

    logic          lvl_found;
    logic          idx_found;
    logic [LW-1:0] sel_lvl;
    logic [N-1:0]  row;
    logic [PW-1:0] base;
    logic [PW-1:0] sel_idx;
    logic [N-1:0]  sel_onehot;
    int            k;

    // Lowest non-empty level wins; within it, first requester at or after that level's pointer.
    always_comb begin
        lvl_found = 1'b0;
        sel_lvl   = '0;
        row       = '0;
        for (int j = 0; j < P; j++) begin
            if (!lvl_found && (i_request[j*N +: N] != '0)) begin
                lvl_found = 1'b1;
                sel_lvl   = LW'(j);
                row       = i_request[j*N +: N];
            end
        end
        base      = ptr[sel_lvl];
        idx_found = 1'b0;
        sel_idx   = '0;
        k         = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(base) + off;
            if (k >= N) k = k - N;
            if (!idx_found && row[k]) begin
                idx_found = 1'b1;
                sel_idx   = PW'(k);
            end
        end
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
    end

    assign next_ptr = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    assign to_hit   = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_grant       <= '0;
            o_grant_level <= '0;
            o_grant_valid <= 1'b0;
            o_timeout     <= 1'b0;
            cnt           <= '0;
            grant_idx     <= '0;
            for (int j = 0; j < P; j++) ptr[j] <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid && (i_request != '0)) begin
                        state         <= WAIT;
                        o_grant       <= sel_onehot;
                        o_grant_level <= sel_lvl;
                        o_grant_valid <= 1'b1;
                        grant_idx     <= sel_idx;
                        cnt           <= '0;
                    end
                end
                WAIT: begin
                    if (i_accept || i_reject || to_hit) begin
                        state         <= IDLE;
                        o_grant       <= '0;
                        o_grant_level <= '0;
                        o_grant_valid <= 1'b0;
                        // Handshake on the timeout edge takes precedence over the timeout.
                        o_timeout     <= !i_accept && !i_reject;
                        if (i_accept) ptr[o_grant_level] <= next_ptr;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISLIP_GRANT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_accept_cnt  <= '0;
            o_timeout_cnt <= '0;
        end else begin
            if (state == WAIT && i_accept && o_accept_cnt != 16'hFFFF)
                o_accept_cnt <= o_accept_cnt + 16'd1;
            if (state == WAIT && !i_accept && !i_reject && to_hit && o_timeout_cnt != 16'hFFFF)
                o_timeout_cnt <= o_timeout_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_islip_grant_arbiter.sv
// Directed bench for islip_grant_arbiter at N=4, P=2, TIMEOUT=3.
module tb_islip_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_request;
    logic       i_req_valid;
    logic       i_accept;
    logic       i_reject;
    logic [3:0] o_grant;
    logic [0:0] o_grant_level;
    logic       o_grant_valid;
    logic       o_timeout;
`ifdef ISLIP_GRANT_STATS_EN
    logic [15:0] o_accept_cnt;
    logic [15:0] o_timeout_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    islip_grant_arbiter #(.N(4), .P(2), .TIMEOUT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_request     (i_request),
        .i_req_valid   (i_req_valid),
        .i_accept      (i_accept),
        .i_reject      (i_reject),
        .o_grant       (o_grant),
        .o_grant_level (o_grant_level),
        .o_grant_valid (o_grant_valid),
`ifdef ISLIP_GRANT_STATS_EN
        .o_accept_cnt  (o_accept_cnt),
        .o_timeout_cnt (o_timeout_cnt),
`endif
        .o_timeout     (o_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_req(input logic [7:0] r);
        i_request   = r;
        i_req_valid = 1'b1;
        step();
        i_req_valid = 1'b0;
        i_request   = '0;
    endtask

    task automatic handshake(input logic a, input logic r);
        i_accept = a;
        i_reject = r;
        step();
        i_accept = 1'b0;
        i_reject = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_request = '0; i_req_valid = 1'b0; i_accept = 1'b0; i_reject = 1'b0;
        step(); step();
        rst = 1'b0;
        n_cmp++; if (o_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
        n_cmp++; if (o_grant_level !== 1'b0) begin n_err++; $display("FAIL reset_level: got %b want 0", o_grant_level); end
        n_cmp++; if (o_grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_grant_valid); end
        n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    endtask

    // ptr0: 0 -> 2 -> 3 -> 2 (wrap through 3,0 to input 1)
    task automatic test_basic();
        step();
        n_cmp++; if (o_grant_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", o_grant_valid); end
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL basic_first: got %b want 0010", o_grant); end
        n_cmp++; if (o_grant_level !== 1'b0) begin n_err++; $display("FAIL basic_level: got %b want 0", o_grant_level); end
        n_cmp++; if (o_grant_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", o_grant_valid); end
        handshake(1'b1, 1'b0);
        n_cmp++; if (o_grant_valid !== 1'b0 || o_grant !== 4'b0000) begin n_err++; $display("FAIL basic_exit: got v=%b g=%b want v=0 g=0000", o_grant_valid, o_grant); end
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0100) begin n_err++; $display("FAIL basic_second: got %b want 0100", o_grant); end
        handshake(1'b1, 1'b0);
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL basic_wrap: got %b want 0010", o_grant); end
        handshake(1'b1, 1'b0);
    endtask

    // ptr0=2, ptr1=0 on entry
    task automatic test_level();
        grant_req(8'b0001_1000);
        n_cmp++; if (o_grant !== 4'b1000 || o_grant_level !== 1'b0) begin n_err++; $display("FAIL level_pri: got g=%b l=%b want g=1000 l=0", o_grant, o_grant_level); end
        handshake(1'b1, 1'b0);
        grant_req(8'b1111_0000);
        n_cmp++; if (o_grant !== 4'b0001 || o_grant_level !== 1'b1) begin n_err++; $display("FAIL level_ptr1_hold: got g=%b l=%b want g=0001 l=1", o_grant, o_grant_level); end
        handshake(1'b1, 1'b0);
        grant_req(8'b0000_1111);
        n_cmp++; if (o_grant !== 4'b0001) begin n_err++; $display("FAIL level_ptr0_wrap: got %b want 0001", o_grant); end
        handshake(1'b1, 1'b0);
`ifdef ISLIP_GRANT_STATS_EN
        n_cmp++; if (o_accept_cnt !== 16'd6) begin n_err++; $display("FAIL stats_accept: got %0d want 6", o_accept_cnt); end
`endif
    endtask

    // ptr0=1, ptr1=1 on entry
    task automatic test_reject();
        grant_req(8'b0000_0010);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL reject_grant: got %b want 0010", o_grant); end
        handshake(1'b0, 1'b1);
        n_cmp++; if (o_grant_valid !== 1'b0) begin n_err++; $display("FAIL reject_exit: got %b want 0", o_grant_valid); end
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL reject_ptr: got %b want 0010", o_grant); end
        handshake(1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        grant_req(8'b0000_0110);
        i_request = 8'b0000_1000; i_req_valid = 1'b1;
        step();
        n_cmp++; if (o_grant !== 4'b0010 || o_timeout !== 1'b0) begin n_err++; $display("FAIL to_hold1: got g=%b t=%b want g=0010 t=0", o_grant, o_timeout); end
        step();
        n_cmp++; if (o_grant_valid !== 1'b1 || o_timeout !== 1'b0) begin n_err++; $display("FAIL to_hold2: got v=%b t=%b want v=1 t=0", o_grant_valid, o_timeout); end
        i_request = '0; i_req_valid = 1'b0;
        step();
        n_cmp++; if (o_timeout !== 1'b1 || o_grant_valid !== 1'b0 || o_grant !== 4'b0000) begin n_err++; $display("FAIL to_pulse: got t=%b v=%b g=%b want t=1 v=0 g=0000", o_timeout, o_grant_valid, o_grant); end
        step();
        n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL to_one_cycle: got %b want 0", o_timeout); end
`ifdef ISLIP_GRANT_STATS_EN
        n_cmp++; if (o_timeout_cnt !== 16'd1) begin n_err++; $display("FAIL stats_timeout: got %0d want 1", o_timeout_cnt); end
`endif
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL to_ptr: got %b want 0010", o_grant); end
        handshake(1'b0, 1'b1);
    endtask

    // ptr0=1 on entry
    task automatic test_both();
        grant_req(8'b0000_0110);
        handshake(1'b1, 1'b1);
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0100) begin n_err++; $display("FAIL both_accept_wins: got %b want 0100", o_grant); end
        step(); step();
        handshake(1'b1, 1'b0);
        n_cmp++; if (o_timeout !== 1'b0 || o_grant_valid !== 1'b0) begin n_err++; $display("FAIL hs_beats_timeout: got t=%b v=%b want t=0 v=0", o_timeout, o_grant_valid); end
        handshake(1'b1, 1'b0);
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL idle_accept_ignored: got %b want 0010", o_grant); end
        handshake(1'b1, 1'b0);
    endtask

    // ptr0=2, ptr1=1 on entry
    task automatic test_reset_wait();
        grant_req(8'b0000_0110);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (o_grant !== 4'b0000 || o_grant_valid !== 1'b0 || o_timeout !== 1'b0 || o_grant_level !== 1'b0) begin n_err++; $display("FAIL rst_wait_outputs: got g=%b v=%b t=%b l=%b want all 0", o_grant, o_grant_valid, o_timeout, o_grant_level); end
        grant_req(8'b0000_0110);
        n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL rst_ptr0: got %b want 0010", o_grant); end
        handshake(1'b0, 1'b1);
        grant_req(8'b0011_0000);
        n_cmp++; if (o_grant !== 4'b0001 || o_grant_level !== 1'b1) begin n_err++; $display("FAIL rst_ptr1: got g=%b l=%b want g=0001 l=1", o_grant, o_grant_level); end
        handshake(1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level();
        test_reject();
        test_timeout();
        test_both();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
